ddr_burst_cmd_gen: RTL and testbench



---
 rtl/ddr_pkg.sv | 23 ++
 rtl/ddr_burst_addr_ctr.sv | 38 +++
 rtl/ddr_burst_cmd_gen.sv | 131 +++++++++++++
 tb/tb_ddr_burst_cmd_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR command path: FSM state encodings and the
// command-FIFO entry layout {wen, addr, word1, word0} used by producer and consumer.
package ddr_pkg;
    localparam int DDR_ADDR_W    = 27;
    localparam int DDR_DATA_W    = 256;
    localparam int DDR_ADDR_STEP = 8;

    localparam int WORD0_LSB = 0;
    localparam int WORD1_LSB = DDR_DATA_W;
    localparam int ADDR_LSB  = 2 * DDR_DATA_W;
    localparam int WEN_BIT   = 2 * DDR_DATA_W + DDR_ADDR_W;
    localparam int ENTRY_W   = WEN_BIT + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH0 = 3'd1,
        S_FETCH1 = 3'd2,
        S_CAP    = 3'd3,
        S_PUSH   = 3'd4,
        S_DRAIN  = 3'd5,
        S_FIN    = 3'd6
    } state_e;
endpackage

// File: rtl/ddr_burst_addr_ctr.sv
// Per-burst address/BRAM/remaining counters; all wrap naturally at their widths.
module ddr_burst_addr_ctr #(
    parameter int ADDR_W    = 27,
    parameter int BRAM_AW   = 10,
    parameter int LEN_W     = 10,
    parameter int ADDR_STEP = 8
) (
    input  logic               clk_200,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [ADDR_W-1:0]  addr_init,
    input  logic [BRAM_AW-1:0] bram_init,
    input  logic [LEN_W-1:0]   len_init,
    output logic [ADDR_W-1:0]  cur_addr,
    output logic [BRAM_AW-1:0] cur_bram,
    output logic               last
);
    logic [LEN_W-1:0] remaining;

    always_ff @(posedge clk_200 or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            cur_bram  <= '0;
            remaining <= '0;
        end else if (load) begin
            cur_addr  <= addr_init;
            cur_bram  <= bram_init;
            remaining <= len_init;
        end else if (step) begin
            cur_addr  <= cur_addr + ADDR_W'(ADDR_STEP);
            cur_bram  <= cur_bram + BRAM_AW'(2);
            remaining <= remaining - LEN_W'(1);
        end
    end

    assign last = (remaining == LEN_W'(1));
endmodule

// File: rtl/ddr_burst_cmd_gen.sv
// Splits a bulk DDR request into per-burst command-FIFO entries, fetching two
// BRAM words per write burst. Optional stall counter under DDR_CMD_PERF_EN.
module ddr_burst_cmd_gen
    import ddr_pkg::*;
#(
    parameter int ADDR_W    = DDR_ADDR_W,
    parameter int DATA_W    = DDR_DATA_W,
    parameter int BRAM_AW   = 10,
    parameter int LEN_W     = 10,
    parameter int ADDR_STEP = DDR_ADDR_STEP
) (
    input  logic                       clk_200,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       ddr_wen_req,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [LEN_W-1:0]           num_bursts,
    input  logic [BRAM_AW-1:0]         bram_base,
    output logic                       busy,
    output logic                       done,
    output logic                       bram_rd_en,
    output logic [BRAM_AW-1:0]         bram_rd_addr,
    input  logic [DATA_W-1:0]          bram_rd_data,
    output logic                       fifo_write_en,
    output logic [2*DATA_W+ADDR_W:0]   fifo_din,
    input  logic                       fifo_full,
    input  logic                       fifo_empty
`ifdef DDR_CMD_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt
`endif
);
    state_e              state, state_nx;
    logic                accept, step, last, wen_q;
    logic [ADDR_W-1:0]   cur_addr;
    logic [BRAM_AW-1:0]  cur_bram;
    logic [DATA_W-1:0]   word0_q, word1_q;

    ddr_burst_addr_ctr #(
        .ADDR_W(ADDR_W), .BRAM_AW(BRAM_AW), .LEN_W(LEN_W), .ADDR_STEP(ADDR_STEP)
    ) u_ctr (
        .clk_200  (clk_200),
        .rst      (rst),
        .load     (accept),
        .step     (step),
        .addr_init(base_addr),
        .bram_init(bram_base),
        .len_init (num_bursts),
        .cur_addr (cur_addr),
        .cur_bram (cur_bram),
        .last     (last)
    );

    always_ff @(posedge clk_200 or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        step          = 1'b0;
        bram_rd_en    = 1'b0;
        bram_rd_addr  = '0;
        fifo_write_en = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = (num_bursts == '0) ? S_FIN : (ddr_wen_req ? S_FETCH0 : S_PUSH);
            end
            S_FETCH0: begin
                bram_rd_en   = 1'b1;
                bram_rd_addr = cur_bram;
                state_nx     = S_FETCH1;
            end
            S_FETCH1: begin
                bram_rd_en   = 1'b1;
                bram_rd_addr = cur_bram + BRAM_AW'(1);
                state_nx     = S_CAP;
            end
            S_CAP: state_nx = S_PUSH;
            // Push is gated combinationally so a full FIFO never sees a write.
            S_PUSH: if (!fifo_full) begin
                fifo_write_en = 1'b1;
                step          = 1'b1;
                state_nx      = last ? S_DRAIN : (wen_q ? S_FETCH0 : S_PUSH);
            end
            S_DRAIN: if (fifo_empty) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Data words are cleared on accept so read entries carry a zero data field.
    always_ff @(posedge clk_200 or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            wen_q   <= 1'b0;
            word0_q <= '0;
            word1_q <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy    <= 1'b1;
                wen_q   <= ddr_wen_req;
                word0_q <= '0;
                word1_q <= '0;
            end
            if (state == S_FETCH1) word0_q <= bram_rd_data;
            if (state == S_CAP)    word1_q <= bram_rd_data;
            if (state == S_FIN) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    assign fifo_din = {wen_q, cur_addr, word1_q, word0_q};

`ifdef DDR_CMD_PERF_EN
    always_ff @(posedge clk_200 or posedge rst) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if (accept)
            perf_stall_cnt <= '0;
        else if (state == S_PUSH && fifo_full && perf_stall_cnt != 32'hFFFF_FFFF)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ddr_burst_cmd_gen.sv
// Directed bench for ddr_burst_cmd_gen with a one-cycle-latency BRAM model (BRAM[i]=i).
module tb_ddr_burst_cmd_gen;
    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 256;
    localparam int BRAM_AW = 10;
    localparam int LEN_W   = 10;
    localparam int FW      = 1 + ADDR_W + 2 * DATA_W;

    logic                clk_200 = 1'b0;
    logic                rst, start, ddr_wen_req, fifo_full, fifo_empty;
    logic [ADDR_W-1:0]   base_addr;
    logic [LEN_W-1:0]    num_bursts;
    logic [BRAM_AW-1:0]  bram_base;
    logic                busy, done, bram_rd_en, fifo_write_en;
    logic [BRAM_AW-1:0]  bram_rd_addr;
    logic [DATA_W-1:0]   bram_rd_data = '0;
    logic [FW-1:0]       fifo_din, din_hold;
`ifdef DDR_CMD_PERF_EN
    logic [31:0]         perf_stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cnt;

    ddr_burst_cmd_gen dut (
        .clk_200      (clk_200),
        .rst          (rst),
        .start        (start),
        .ddr_wen_req  (ddr_wen_req),
        .base_addr    (base_addr),
        .num_bursts   (num_bursts),
        .bram_base    (bram_base),
        .busy         (busy),
        .done         (done),
        .bram_rd_en   (bram_rd_en),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_data (bram_rd_data),
        .fifo_write_en(fifo_write_en),
        .fifo_din     (fifo_din),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty)
`ifdef DDR_CMD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk_200 = ~clk_200;

    always @(posedge clk_200)
        if (bram_rd_en) bram_rd_data <= DATA_W'(bram_rd_addr);

    task automatic tick();
        @(posedge clk_200);
        #1;
    endtask

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] ent(input logic wen, input int addr, input int w1, input int w0);
        return {wen, ADDR_W'(addr), DATA_W'(w1), DATA_W'(w0)};
    endfunction

    task automatic req(input logic wen, input int addr, input int n, input int bb);
        ddr_wen_req = wen;
        base_addr   = ADDR_W'(addr);
        num_bursts  = LEN_W'(n);
        bram_base   = BRAM_AW'(bb);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ddr_wen_req = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0;
        base_addr = '0; num_bursts = '0; bram_base = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", bram_rd_en, 0);
        chk("rst_rd_addr", bram_rd_addr, 0);
        chk("rst_wr_en", fifo_write_en, 0);
        chk("rst_din", fifo_din, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Write, 3 bursts from 0x100, BRAM words 0..5; pushes 4 cycles apart
        req(1'b1, 'h100, 3, 0);
        chk("w_busy", busy, 1);
        chk("w_rd_addr0", bram_rd_addr, 0);
        for (int b = 0; b < 3; b++) begin
            chk("w_fetch0_en", bram_rd_en, 1);
            chk("w_fetch0_nowr", fifo_write_en, 0);
            tick();
            chk("w_fetch1_addr", bram_rd_addr, BRAM_AW'(2 * b + 1));
            tick(); tick();
            chk("w_push_en", fifo_write_en, 1);
            chk("w_push_din", fifo_din, ent(1'b1, 'h100 + 8 * b, 2 * b + 1, 2 * b));
            tick();
        end
        chk("w_drain_nowr", fifo_write_en, 0);
        tick();
        chk("w_drain_busy", busy, 1);
        chk("w_drain_done", done, 0);
        fifo_empty = 1'b1;
        tick();
        chk("w_fin_done", done, 0);
        tick();
        chk("w_done", done, 1);
        chk("w_busy_fall", busy, 0);
        tick();
        chk("w_done_1cyc", done, 0);

        // Read, 2 bursts with address wrap, back-to-back pushes, zero data
        req(1'b0, 'h7FFFFF8, 2, 0);
        chk("r_push0_en", fifo_write_en, 1);
        chk("r_push0_din", fifo_din, ent(1'b0, 'h7FFFFF8, 0, 0));
        chk("r_no_bram", bram_rd_en, 0);
        tick();
        chk("r_push1_en", fifo_write_en, 1);
        chk("r_push1_wrap", fifo_din, ent(1'b0, 0, 0, 0));
        tick();
        chk("r_drain_nowr", fifo_write_en, 0);
        tick(); tick();
        chk("r_done", done, 1);
        chk("r_busy_fall", busy, 0);
        tick();

        // Zero-length request
        req(1'b1, 'h40, 0, 0);
        chk("z_busy1", busy, 1);
        chk("z_done_early", done, 0);
        chk("z_nowr", fifo_write_en, 0);
        tick();
        chk("z_done", done, 1);
        chk("z_busy0", busy, 0);
        tick();
        chk("z_done_1cyc", done, 0);

        // Backpressure: FIFO full for 10 PUSH cycles
        fifo_full = 1'b1;
        req(1'b1, 'h200, 1, 10);
        tick(); tick(); tick();
        chk("f_blocked", fifo_write_en, 0);
        din_hold = fifo_din;
        chk("f_din", din_hold, ent(1'b1, 'h200, 11, 10));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("f_blocked_loop", fifo_write_en, 0);
            chk("f_din_stable", fifo_din, din_hold);
            chk("f_busy", busy, 1);
        end
        fifo_full = 1'b0;
        #1;
        chk("f_release", fifo_write_en, 1);
        tick();
        chk("f_after_push", fifo_write_en, 0);
`ifdef DDR_CMD_PERF_EN
        chk("f_perf", perf_stall_cnt, 10);
`endif
        tick(); tick();
        chk("f_done", done, 1);
`ifdef DDR_CMD_PERF_EN
        tick();
        chk("f_perf_hold", perf_stall_cnt, 10);
`endif

        // Async reset during CAP of burst 2 of 4
        fifo_empty = 1'b0;
        req(1'b1, 'h300, 4, 'h20);
        tick(); tick(); tick();
        chk("x_push1", fifo_write_en, 1);
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("x_busy", busy, 0);
        chk("x_din", fifo_din, 0);
        chk("x_wr", fifo_write_en, 0);
        chk("x_rd_en", bram_rd_en, 0);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (fifo_write_en || done) cnt++;
        end
        chk("x_no_activity", cnt, 0);
        fifo_empty = 1'b1;
        req(1'b0, 'h40, 1, 0);
        chk("x_new_push", fifo_write_en, 1);
        chk("x_new_din", fifo_din, ent(1'b0, 'h40, 0, 0));
        tick(); tick(); tick();
        chk("x_new_done", done, 1);
        tick();

        // Start re-asserted while busy with a different address is ignored
        fifo_empty = 1'b0;
        req(1'b1, 'h500, 2, 0);
        start = 1'b1;
        base_addr = ADDR_W'('h900);
        tick(); tick(); tick();
        chk("i_push0", fifo_din, ent(1'b1, 'h500, 1, 0));
        tick(); tick(); tick(); tick();
        chk("i_push1_en", fifo_write_en, 1);
        chk("i_push1", fifo_din, ent(1'b1, 'h508, 3, 2));
        start = 1'b0;
        fifo_empty = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) cnt++;
        end
        chk("i_done_once", cnt, 1);
        chk("i_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
